// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_SEND = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam int START_TIMEOUT_DEF = 1023;
  localparam int UART_BYTE_W       = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning last+1, last+2, ... modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int               cand;
  logic [IDX_W-1:0] c;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    c     = '0;
    // k = NUM_REQ wraps back to last itself, so it is considered last
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_i) + k) % NUM_REQ;
      c    = IDX_W'(cand);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// sequencing the transmit/is_transmitting handshake with a start timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_byte_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           start_err_o,
  output logic                           err_sticky_o,
  output logic                           busy_o,
  output logic                           transmit_o,
  output logic [UART_BYTE_W-1:0]         tx_byte_o,
  input  logic                           is_transmitting_i
);
  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam int               TMR_W   = $clog2(START_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(START_TIMEOUT);

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   start_err_q, start_err_d;
  logic                   err_sticky_q, err_sticky_d;
  logic                   transmit_q, transmit_d;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       owner_q, owner_d;

  logic [NUM_REQ-1:0]                  pick_gnt;
  logic [IDX_W-1:0]                    pick_idx;
  logic [NUM_REQ-1:0][UART_BYTE_W-1:0] req_bytes;

  assign req_bytes = req_byte_i;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      start_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      transmit_q   <= 1'b0;
      tx_byte_q    <= '0;
      timer_q      <= '0;
      last_q       <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
      err_sticky_q <= err_sticky_d;
      transmit_q   <= transmit_d;
      tx_byte_q    <= tx_byte_d;
      timer_q      <= timer_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (|req_i) state_d = S_WAIT;
      S_WAIT: begin
        // a UART already busy on entry counts as having started our byte
        if (is_transmitting_i)      state_d = S_SEND;
        else if (timer_q == TMR_MAX) state_d = S_IDLE;
      end
      S_SEND: if (!is_transmitting_i) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    done_d       = '0;
    start_err_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    transmit_d   = transmit_q;
    tx_byte_d    = tx_byte_q;
    timer_d      = timer_q;
    last_d       = last_q;
    owner_d      = owner_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d    = pick_gnt;
          owner_d    = pick_idx;
          tx_byte_d  = req_bytes[pick_idx];
          transmit_d = 1'b1;
          timer_d    = '0;
        end
      end
      S_WAIT: begin
        if (is_transmitting_i) begin
          transmit_d = 1'b0;
        end else if (timer_q == TMR_MAX) begin
          // aborted owner drops to lowest priority like a completed one
          transmit_d   = 1'b0;
          grant_d      = '0;
          start_err_d  = 1'b1;
          err_sticky_d = 1'b1;
          last_d       = owner_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = grant_q;
        grant_d = '0;
        last_d  = owner_q;
      end
      default: ;
    endcase
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign start_err_o  = start_err_q;
  assign err_sticky_o = err_sticky_q;
  assign transmit_o   = transmit_q;
  assign tx_byte_o    = tx_byte_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a transfer-timeline model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int T  = 15;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [8*N-1:0] req_byte_i;
  logic [N-1:0]   grant_o, done_o;
  logic           start_err_o, err_sticky_o, busy_o, transmit_o;
  logic [7:0]     tx_byte_o;
  logic           is_transmitting_i;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_i             (req_i),
    .req_byte_i        (req_byte_i),
    .grant_o           (grant_o),
    .done_o            (done_o),
    .start_err_o       (start_err_o),
    .err_sticky_o      (err_sticky_o),
    .busy_o            (busy_o),
    .transmit_o        (transmit_o),
    .tx_byte_o         (tx_byte_o),
    .is_transmitting_i (is_transmitting_i)
  );

  int checks = 0, failures = 0, cyc = 0;

  // model: one transfer described by grant cycle G, owner w, uart delay d, busy length L
  bit         m_act, m_tmo, m_sticky;
  int         m_G, m_w, m_d, m_L, m_last;
  logic [7:0] m_byte;

  int d_cfg, L_cfg, raise_pct;
  bit rand_dl, auto_req, drop_on_done, rand_misc;

  bit u_arm;
  int u_t0, u_d, u_L;

  int         g_log[$];
  logic [7:0] gb_log[$];
  int         g_cyc, tx_rise_cyc, tx_fall_cyc, serr_cyc, done_cyc, done_tot, own;
  int         done_cnt[N];
  logic [N-1:0] prev_grant;
  logic         prev_tx;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) if (r[IW'((last + k) % N)]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int glog(int i);
    return (g_log.size() > i) ? g_log[i] : -1;
  endfunction

  function automatic logic [7:0] gblog(int i);
    return (gb_log.size() > i) ? gb_log[i] : 8'hxx;
  endfunction

  task automatic model_reset();
    m_act = 0; m_last = N - 1; m_sticky = 0; m_byte = 8'h00; m_w = 0;
  endtask

  task automatic clear_logs();
    g_log.delete(); gb_log.delete();
    done_tot = 0; serr_cyc = -1; done_cyc = -1;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
  endtask

  task automatic pick_dl();
    int r;
    if (rand_dl) begin
      r = int'($urandom % 10);
      if (r < 6)       m_d = int'($urandom % 5);
      else if (r == 6) m_d = T;
      else if (r == 7) m_d = T + 1;
      else if (r == 8) m_d = 1000;
      else             m_d = int'($urandom % 3);
      m_L = 1 + int'($urandom % 6);
    end else begin
      m_d = d_cfg; m_L = L_cfg;
    end
  endtask

  task automatic step();
    logic [N-1:0]   pr, oh, eg, ed;
    logic [8*N-1:0] pb;
    logic           prst, es, ebusy, etx;
    int             end_c, fin, tx_end;
    pr = req_i; pb = req_byte_i; prst = rst;
    @(posedge clk); #1; cyc++;
    if (prst) model_reset();
    else if (!m_act && pr != '0) begin
      m_w = rr_pick(pr, m_last); m_act = 1; m_G = cyc;
      m_byte = pb[8*m_w +: 8];
      pick_dl();
      m_tmo = (m_d > T);
    end
    end_c  = m_tmo ? m_G + T : m_G + m_d + m_L + 1;
    fin    = end_c + 1;
    tx_end = m_tmo ? m_G + T : m_G + m_d;
    oh = '0; oh[IW'(m_w)] = 1'b1;
    eg    = (m_act && cyc <= end_c) ? oh : '0;
    ed    = (m_act && !m_tmo && cyc == fin) ? oh : '0;
    es    = m_act && m_tmo && cyc == fin;
    ebusy = m_act && cyc <= end_c;
    etx   = m_act && cyc <= tx_end;
    chk("grant", grant_o, eg);
    chk("done", done_o, ed);
    chk("start_err", start_err_o, es);
    chk("err_sticky", err_sticky_o, m_sticky || es);
    chk("busy", busy_o, ebusy);
    chk("transmit", transmit_o, etx);
    chk("tx_byte", tx_byte_o, m_byte);
    if (m_act && cyc == fin) begin
      m_act = 0; m_last = m_w;
      if (m_tmo) m_sticky = 1;
    end
    // observation logs for the directed expectations
    if (grant_o != '0 && prev_grant == '0) begin
      g_log.push_back($clog2(grant_o)); gb_log.push_back(tx_byte_o); g_cyc = cyc;
    end
    if (grant_o != '0) own = $clog2(grant_o);
    prev_grant = grant_o;
    if (transmit_o && !prev_tx) tx_rise_cyc = cyc;
    if (!transmit_o && prev_tx) tx_fall_cyc = cyc;
    prev_tx = transmit_o;
    if (start_err_o) serr_cyc = cyc;
    for (int i = 0; i < N; i++) if (done_o[i]) begin done_cnt[i]++; done_tot++; done_cyc = cyc; end
    // uart: busy from d cycles after it first sees transmit, for L cycles
    if (!u_arm && transmit_o) begin u_arm = 1; u_t0 = cyc; u_d = m_d; u_L = m_L; end
    else if (u_arm && grant_o == '0) u_arm = 0;
    is_transmitting_i = u_arm && cyc >= u_t0 + u_d && cyc < u_t0 + u_d + u_L;
    // requesters
    if (drop_on_done) begin
      req_i = req_i & ~done_o;
      if (start_err_o) req_i[IW'(own)] = 1'b0;
    end
    if (auto_req)
      for (int i = 0; i < N; i++)
        if (!req_i[i] && ($urandom % 100) < raise_pct) begin
          req_i[i] = 1'b1; req_byte_i[8*i +: 8] = 8'($urandom);
        end
    if (rand_misc) begin
      if ($urandom % 8 == 0) req_byte_i[8*($urandom % N) +: 8] = 8'($urandom);
      if (grant_o != '0 && $urandom % 40 == 0) req_i[IW'(own)] = 1'b0;
      rst = ($urandom % 500 == 0);
    end
  endtask

  task automatic run_until_done(int n, int budget, string nm);
    for (int k = 0; k < budget && done_tot < n; k++) step();
    chk(nm, done_tot >= n, 1);
  endtask

  task automatic run_until_send(int budget, string nm);
    for (int k = 0; k < budget && !(grant_o != '0 && !transmit_o); k++) step();
    chk(nm, grant_o != '0 && !transmit_o, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  int n0;

  initial begin
    rst = 1'b1; req_i = '0; req_byte_i = '0; is_transmitting_i = 1'b0;
    d_cfg = 2; L_cfg = 4; raise_pct = 0;
    rand_dl = 0; auto_req = 0; drop_on_done = 1; rand_misc = 0;
    u_arm = 0; prev_grant = '0; prev_tx = 1'b0; own = 0;
    model_reset(); clear_logs();
    step(); step();
    rst = 1'b0;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx_byte", tx_byte_o, 0);
    chk("rst_sticky", err_sticky_o, 0);

    // single request, uart starts 2 cycles after transmit and stays busy 100 cycles
    d_cfg = 2; L_cfg = 100; clear_logs();
    req_byte_i[23:16] = 8'h41; req_i = 4'b0100;
    run_until_done(1, 400, "t1_wait");
    chk("t1_idx", glog(0), 2);
    chk("t1_byte", gblog(0), 8'h41);
    chk("t1_tx_drop", tx_fall_cyc - tx_rise_cyc, 3);
    chk("t1_done_lat", done_cyc - g_cyc, 104);
    chk("t1_done2", done_cnt[2], 1);
    step(); step();
    chk("t1_idle", busy_o, 0);

    // simultaneous held requests
    reset_pulse(); clear_logs();
    drop_on_done = 0; d_cfg = 1; L_cfg = 3;
    req_byte_i = 32'h33323130; req_i = 4'b1011;
    for (int k = 0; k < 200 && g_log.size() < 4; k++) step();
    req_i = '0;
    chk("t2_o0", glog(0), 0); chk("t2_o1", glog(1), 1);
    chk("t2_o2", glog(2), 3); chk("t2_o3", glog(3), 0);
    chk("t2_b0", gblog(0), 8'h30); chk("t2_b2", gblog(2), 8'h33);
    for (int k = 0; k < 20; k++) step();

    // fairness: everyone requesting continuously
    reset_pulse(); clear_logs();
    d_cfg = 0; L_cfg = 2; req_byte_i = 32'hA3A2A1A0; req_i = 4'b1111;
    run_until_done(12, 500, "t3_wait");
    req_i = '0;
    for (int i = 0; i < 12; i++) chk($sformatf("t3_order%0d", i), glog(i), i % 4);
    for (int i = 0; i < N; i++) chk($sformatf("t3_cnt%0d", i), done_cnt[i], 3);
    for (int k = 0; k < 10; k++) step();

    // start timeout, then the next pending requester succeeds
    reset_pulse(); clear_logs();
    drop_on_done = 1; d_cfg = 1000; L_cfg = 2;
    req_byte_i = 32'h44332211; req_i = 4'b1010;
    for (int k = 0; k < 100 && serr_cyc < 0; k++) step();
    d_cfg = 2;
    chk("t4_lat", serr_cyc - tx_rise_cyc, 16);
    chk("t4_sticky", err_sticky_o, 1);
    chk("t4_first", glog(0), 1);
    run_until_done(1, 200, "t4_wait");
    chk("t4_next", glog(1), 3);
    chk("t4_nodone1", done_cnt[1], 0);
    chk("t4_sticky2", err_sticky_o, 1);

    // reset during the send phase
    for (int k = 0; k < 10; k++) step();
    d_cfg = 1; L_cfg = 20; req_i = 4'b0001;
    run_until_send(50, "t5_send");
    rst = 1'b1; req_i = 4'b1001; step(); rst = 1'b0;
    chk("t5_grant", grant_o, 0); chk("t5_done", done_o, 0);
    chk("t5_tx", transmit_o, 0); chk("t5_sticky", err_sticky_o, 0);
    clear_logs();
    run_until_done(2, 300, "t5_wait");
    chk("t5_first", glog(0), 0);
    chk("t5_second", glog(1), 3);

    // req dropped and byte changed mid-transfer
    for (int k = 0; k < 10; k++) step();
    clear_logs(); d_cfg = 1; L_cfg = 10;
    req_byte_i[23:16] = 8'h55; req_i = 4'b0100;
    run_until_send(50, "t6_send");
    req_i[2] = 1'b0; req_byte_i[23:16] = 8'hAA;
    for (int k = 0; k < 100 && done_tot < 1; k++) begin
      step();
      if (grant_o != '0) chk("t6_byte", tx_byte_o, 8'h55);
    end
    chk("t6_done2", done_cnt[2], 1);
    n0 = g_log.size();
    for (int k = 0; k < 10; k++) step();
    chk("t6_nogrant", g_log.size(), n0);

    // randomised traffic
    reset_pulse(); clear_logs();
    auto_req = 1; raise_pct = 20; rand_dl = 1; rand_misc = 1;
    for (int k = 0; k < 4000; k++) step();
    auto_req = 0; rand_misc = 0; rst = 1'b0;
    for (int k = 0; k < 300; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
